// File: rtl/keccak_round_sequencer.sv
// Round controller for the 64-slice Keccak datapath: load, NUM_ROUNDS
// start/wait/capture rounds with a WAIT watchdog, then a valid/ready result.
module keccak_round_sequencer #(
    parameter int NUM_ROUNDS = 24,
    parameter int WAIT_MAX   = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       stage_start,
    input  logic       stage_all_ready,
    output logic       state_sel,
    output logic       state_we,
    output logic [4:0] round_idx,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_CAPTURE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS - 1);
    localparam logic [7:0] WDOG_LAST  = 8'(WAIT_MAX - 1);

    state_t     state_q, state_d;
    logic [4:0] round_q, round_d;
    logic [7:0] wdog_q,  wdog_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            round_q <= 5'd0;
            wdog_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            wdog_q  <= wdog_d;
        end
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        wdog_d  = wdog_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                round_d = 5'd0;
                state_d = S_START;
            end
            S_START: begin
                wdog_d  = 8'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Ready wins over the watchdog in the last allowed cycle.
                if (stage_all_ready) begin
                    state_d = S_CAPTURE;
                end else if (wdog_q == WDOG_LAST) begin
                    state_d = S_ERR;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
            end
            S_CAPTURE: begin
                if (round_q == LAST_ROUND) begin
                    state_d = S_DONE;
                end else begin
                    round_d = round_q + 5'd1;
                    state_d = S_START;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    round_d = 5'd0;
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are pure decodes so reset reaches them without a clock edge.
    assign in_ready    = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign stage_start = (state_q == S_START);
    assign state_sel   = (state_q == S_CAPTURE);
    assign state_we    = (state_q == S_LOAD) || (state_q == S_CAPTURE);
    assign out_valid   = (state_q == S_DONE);
    assign timeout_err = (state_q == S_ERR);
    assign round_idx   = round_q;

endmodule
